// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store bus interface.
// Holds size encodings, the FSM state encoding, the default timeout and
// the misalignment helper used when LSU_MISALIGN_CHECK_EN is defined.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int TIMEOUT_CYC_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } lsu_state_e;

  // Half needs addr[0]=0; word (and the 11 encoding, treated as word) needs addr[1:0]=0.
  function automatic logic lsu_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store bus interface.
// Generates byte enables and replicated store data from the low address
// bits and size, and extracts/extends a load lane from the raw bus word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store side: byte enables and lane replication so any lane carries the data.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
    endcase
  end

  // Load side: pick the addressed lane, then sign- or zero-extend it.
  always_comb begin
    byte_s  = 8'h00;
    half_s  = 16'h0000;
    rdata_o = rdata_i;
    case (addr_lo_i)
      2'b00:   byte_s = rdata_i[7:0];
      2'b01:   byte_s = rdata_i[15:8];
      2'b10:   byte_s = rdata_i[23:16];
      default: byte_s = rdata_i[31:24];
    endcase
    half_s = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SZ_BYTE: rdata_o = uns_i ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
      SZ_HALF: rdata_o = uns_i ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_bus_if.sv
// lsu_bus_if: turns the control FSM's memory strobes into a single
// request/grant/response transaction on the data-memory bus.
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject misaligned
// half/word accesses with err and no bus request. Undefined (default),
// the low address bits are simply truncated by the lane logic.
// All outputs are driven from flops; reset is synchronous, active-low.
module lsu_bus_if
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_en,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int            CW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        we_q, we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;

  logic        bus_req_q, bus_we_q, done_q, err_q, busy_q;
  logic [31:0] bus_addr_q, bus_wdata_q;
  logic [3:0]  bus_be_q;

  logic        latch_s, fail_s, capture_s, timeout_s, misalign_s;
  logic [1:0]  al_addr_s, al_size_s;
  logic        al_uns_s;
  logic [31:0] al_wdata_s, al_wdata_rep_s, al_rdata_ext_s;
  logic [3:0]  al_be_s;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign_s = lsu_misaligned(addr[1:0], size);
`else
  assign misalign_s = 1'b0;
`endif

  assign timeout_s = (cnt_q == CNT_LAST);

  // Feed the lane logic from the live inputs while idle (to register the
  // request fields on entry) and from the latched request afterwards.
  always_comb begin
    if (state_q == ST_IDLE) begin
      al_addr_s  = addr[1:0];
      al_size_s  = size;
      al_uns_s   = uns;
      al_wdata_s = wdata;
    end else begin
      al_addr_s  = addr_q[1:0];
      al_size_s  = size_q;
      al_uns_s   = uns_q;
      al_wdata_s = wdata_q;
    end
  end

  lsu_align u_align (
    .addr_lo_i (al_addr_s),
    .size_i    (al_size_s),
    .uns_i     (al_uns_s),
    .wdata_i   (al_wdata_s),
    .rdata_i   (bus_rdata),
    .be_o      (al_be_s),
    .wdata_o   (al_wdata_rep_s),
    .rdata_o   (al_rdata_ext_s)
  );

  // Next-state logic; gnt and rvalid only count in their own states.
  always_comb begin
    state_d   = state_q;
    latch_s   = 1'b0;
    fail_s    = 1'b0;
    capture_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_en) begin
          if ((mem_read_en ^ mem_write_en) && !misalign_s) begin
            state_d = ST_REQ;
            latch_s = 1'b1;
          end else begin
            state_d = ST_DONE;
            fail_s  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus_gnt && we_q) begin
          state_d = ST_DONE;
        end else if (timeout_s) begin
          state_d = ST_DONE;
          fail_s  = 1'b1;
        end else if (bus_gnt) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (bus_rvalid) begin
          state_d   = ST_DONE;
          capture_s = 1'b1;
        end else if (timeout_s) begin
          state_d = ST_DONE;
          fail_s  = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values for the latched request, timeout counter and load result.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    if (latch_s) begin
      addr_d  = addr;
      wdata_d = wdata;
      size_d  = size;
      uns_d   = uns;
      we_d    = mem_write_en;
      cnt_d   = {CW{1'b0}};
    end else if ((state_q == ST_REQ) || (state_q == ST_WAIT)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
    if (capture_s) begin
      rdata_d = al_rdata_ext_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State, latched request, counter and load data registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      rdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Output flops decoded from the next state so each output lines up with its state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      bus_addr_q  <= 32'h0000_0000;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= 32'h0000_0000;
    end else begin
      bus_req_q <= (state_d == ST_REQ);
      bus_we_q  <= (state_d == ST_REQ) && we_d;
      done_q    <= (state_d == ST_DONE);
      err_q     <= fail_s;
      busy_q    <= (state_d != ST_IDLE);
      if (latch_s) begin
        bus_addr_q  <= {addr[31:2], 2'b00};
        bus_be_q    <= al_be_s;
        bus_wdata_q <= al_wdata_rep_s;
      end else begin
        bus_addr_q  <= bus_addr_q;
        bus_be_q    <= bus_be_q;
        bus_wdata_q <= bus_wdata_q;
      end
    end
  end

  assign rdata     = rdata_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_bus_if.sv
// tb_lsu_bus_if: directed self-checking bench for lsu_bus_if.
// Inputs change and outputs are sampled 1 time unit after each rising edge;
// "cycle N" is the interval following the Nth edge after the strobe.
module tb_lsu_bus_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_en, mem_read_en, mem_write_en;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] rdata;
  logic        done, busy, err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  lsu_bus_if #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_en(mem_en), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .addr(addr), .wdata(wdata), .size(size), .uns(uns),
    .rdata(rdata), .done(done), .busy(busy), .err(err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one strobe for a single cycle; returns in cycle 1.
  task automatic start(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] sz, input logic u);
    mem_en = 1'b1; mem_read_en = rd; mem_write_en = wr;
    addr = a; wdata = wd; size = sz; uns = u;
    tick();
    mem_en = 1'b0; mem_read_en = 1'b0; mem_write_en = 1'b0;
    addr = 32'hFFFF_FFFF; wdata = 32'h0BAD_0BAD; size = 2'b00; uns = 1'b0;
  endtask

  task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input logic [31:0] ea, input logic [3:0] ebe,
                          input logic [31:0] ewd);
    start(1'b0, 1'b1, a, wd, sz, 1'b0);
    check_eq({tag, " req"},   32'(bus_req), 32'd1);
    check_eq({tag, " we"},    32'(bus_we), 32'd1);
    check_eq({tag, " addr"},  bus_addr, ea);
    check_eq({tag, " be"},    32'(bus_be), 32'(ebe));
    check_eq({tag, " wdata"}, bus_wdata, ewd);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    check_eq({tag, " done"},  32'({done, err, bus_req, busy}), 32'b1001);
    tick();
    check_eq({tag, " idle"},  32'({done, err, bus_req, busy}), 32'b0000);
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic u, input logic [31:0] ea, input logic [3:0] ebe,
                         input logic [31:0] raw, input logic [31:0] erd);
    start(1'b1, 1'b0, a, 32'h0, sz, u);
    check_eq({tag, " req"},  32'({bus_req, bus_we}), 32'b10);
    check_eq({tag, " addr"}, bus_addr, ea);
    check_eq({tag, " be"},   32'(bus_be), 32'(ebe));
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    check_eq({tag, " wait"}, 32'({done, bus_req, busy}), 32'b001);
    bus_rvalid = 1'b1; bus_rdata = raw;
    tick();
    bus_rvalid = 1'b0; bus_rdata = 32'h0;
    check_eq({tag, " done"},  32'({done, err}), 32'b10);
    check_eq({tag, " rdata"}, rdata, erd);
    tick();
    check_eq({tag, " hold"},  rdata, erd);
    last_rd = erd;
  endtask

  initial begin
    int hi;
    rst_n = 1'b0; mem_en = 1'b0; mem_read_en = 1'b0; mem_write_en = 1'b0;
    addr = 32'h0; wdata = 32'h0; size = 2'b00; uns = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    last_rd = 32'h0;
    tick(); tick(); tick();
    check_eq("rst ctl",   32'({bus_req, bus_we, done, err, busy}), 32'd0);
    check_eq("rst addr",  bus_addr, 32'h0);
    check_eq("rst be",    32'(bus_be), 32'h0);
    check_eq("rst wdata", bus_wdata, 32'h0);
    check_eq("rst rdata", rdata, 32'h0);
    rst_n = 1'b1;
    tick();

    // Stores: byte lanes 3 and 1, half upper lane, full word.
    do_store("st_b3", 32'h0000_1003, 32'h0000_00A5, 2'b00, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5);
    do_store("st_b1", 32'h0000_1001, 32'h0000_003C, 2'b00, 32'h0000_1000, 4'b0010, 32'h3C3C_3C3C);
    do_store("st_h2", 32'h0000_6002, 32'h1234_BEEF, 2'b01, 32'h0000_6000, 4'b1100, 32'hBEEF_BEEF);
    do_store("st_w",  32'h0000_7000, 32'hDEAD_BEEF, 2'b10, 32'h0000_7000, 4'b1111, 32'hDEAD_BEEF);

    // Loads: half signed/unsigned, signed byte lane 1.
    do_load("ld_hs", 32'h0000_2002, 2'b01, 1'b0, 32'h0000_2000, 4'b1100, 32'h8001_0000, 32'hFFFF_8001);
    do_load("ld_hu", 32'h0000_2002, 2'b01, 1'b1, 32'h0000_2000, 4'b1100, 32'h8001_0000, 32'h0000_8001);
    do_load("ld_bs", 32'h0000_2001, 2'b00, 1'b0, 32'h0000_2000, 4'b0010, 32'h1122_8033, 32'hFFFF_FF80);

    // Misaligned word load.
`ifdef LSU_MISALIGN_CHECK_EN
    start(1'b1, 1'b0, 32'h0000_3002, 32'h0, 2'b10, 1'b0);
    check_eq("mis done", 32'({done, err, bus_req}), 32'b110);
    tick();
    check_eq("mis idle", 32'({done, err, bus_req, busy}), 32'b0000);
    check_eq("mis rdata", rdata, last_rd);
`else
    do_load("ld_wmis", 32'h0000_3002, 2'b10, 1'b0, 32'h0000_3000, 4'b1111, 32'hCAFE_BABE, 32'hCAFE_BABE);
`endif

    // Illegal strobes: both and neither direction.
    start(1'b1, 1'b1, 32'h0000_0100, 32'h0, 2'b10, 1'b0);
    check_eq("ill both", 32'({done, err, bus_req, busy}), 32'b1101);
    tick();
    check_eq("ill both idle", 32'({done, err, busy}), 32'b000);
    start(1'b0, 1'b0, 32'h0000_0100, 32'h0, 2'b10, 1'b0);
    check_eq("ill none", 32'({done, err, bus_req, busy}), 32'b1101);
    tick();

    // Delayed grant (cycle 4) and response (cycle 6); stray rvalid in REQ ignored.
    start(1'b1, 1'b0, 32'h0000_4000, 32'h0, 2'b10, 1'b0);
    bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_DEAD;
    for (int i = 1; i <= 3; i++) begin
      check_eq("dly req", 32'({bus_req, bus_we, bus_be}), 32'b10_1111);
      check_eq("dly addr", bus_addr, 32'h0000_4000);
      tick();
    end
    check_eq("dly req4", 32'({bus_req, done}), 32'b10);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    check_eq("dly wait5", 32'({bus_req, done, busy}), 32'b001);
    check_eq("dly rd5", rdata, last_rd);
    tick();
    check_eq("dly wait6", 32'({done, busy}), 32'b01);
    bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
    tick();
    bus_rvalid = 1'b0; bus_rdata = 32'h0;
    check_eq("dly done7", 32'({done, err}), 32'b10);
    check_eq("dly rdata", rdata, 32'h1234_5678);
    tick();
    check_eq("dly idle", 32'({done, busy}), 32'b00);

    // Timeout: 16 cycles of REQ without grant, then done+err.
    start(1'b1, 1'b0, 32'h0000_5001, 32'h0, 2'b00, 1'b0);
    hi = 0;
    for (int i = 1; i <= 16; i++) begin
      if (bus_req === 1'b1 && done === 1'b0) hi++;
      tick();
    end
    check_eq("to req cycles", 32'(hi), 32'd16);
    check_eq("to done", 32'({done, err, bus_req}), 32'b110);
    check_eq("to rdata", rdata, 32'h1234_5678);
    tick();
    check_eq("to idle", 32'({done, err, busy}), 32'b000);

    // Reset pulsed in WAIT, then a late rvalid.
    start(1'b1, 1'b0, 32'h0000_8000, 32'h0, 2'b10, 1'b0);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    check_eq("rw wait", 32'({busy, bus_req}), 32'b10);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("rw rst", 32'({busy, bus_req, done}), 32'b000);
    check_eq("rw rst rdata", rdata, 32'h0);
    bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_0000;
    tick();
    bus_rvalid = 1'b0; bus_rdata = 32'h0;
    check_eq("rw late", 32'({done, busy, err}), 32'b000);
    check_eq("rw late rdata", rdata, 32'h0);
    tick();
    check_eq("rw after", 32'({done, busy}), 32'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lsu_bus_if.md
# lsu_bus_if

Load/store bus interface sitting directly downstream of the multicycle control FSM. It turns the FSM's `mem_en`/`mem_read_en`/`mem_write_en` strobes plus the ALU-computed address into one request/grant/response transaction on the data-memory bus. It performs byte-lane steering for stores, extracts and sign- or zero-extends load data, and reports completion or error back to the core.

## Interface
- `TIMEOUT_CYC`, default 16: cycles allowed in REQ+WAIT before the access aborts with error; minimum 2.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset. Synchronous, active-low.
- `mem_en` in 1: access strobe from the control FSM; sampled only in IDLE.
- `mem_read_en` in 1: load request, qualified by `mem_en`.
- `mem_write_en` in 1: store request, qualified by `mem_en`.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-aligned.
- `size` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `uns` in 1: zero-extend loads when 1, sign-extend when 0.
- `rdata` out 32: extended load data; holds its value until the next load completes.
- `done` out 1: one-cycle completion pulse.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: one-cycle pulse, coincident with `done`, on a failed access.
- `bus_req` out 1, `bus_we` out 1, `bus_addr` out 32, `bus_be` out 4, `bus_wdata` out 32: request channel.
- `bus_gnt` in 1: request accepted this cycle.
- `bus_rvalid` in 1, `bus_rdata` in 32: read response channel.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE, entry condition:
  - `mem_en` is high.
  - Exactly one of `mem_read_en` or `mem_write_en` is high.
  - On entry, latch `addr`, `wdata`, `size`, `uns` and direction, then go to REQ.
- IDLE, `mem_en` with both or neither of read/write high: go to DONE with error; no bus activity.
- REQ:
  - `bus_req` is high; request fields are driven from the latched values.
  - `bus_gnt` on a write: go to DONE.
  - `bus_gnt` on a read: go to WAIT.
  - Request fields must stay stable until `bus_gnt`.
- WAIT: on `bus_rvalid`, capture the extracted and extended `bus_rdata` into `rdata`, then go to DONE.
- DONE: pulse `done` (and `err` if flagged), then return to IDLE.
- Timeout: a free-running counter starts on REQ entry. If it reaches `TIMEOUT_CYC` while in REQ or WAIT, go to DONE with error, drop `bus_req`, and leave `rdata` unchanged.
- Request channel encoding:
  - `bus_addr` = {addr[31:2], 2'b00}.
  - `bus_be`: byte is 0001<<addr[1:0]; half is 0011<<{addr[1],1'b0}; word is 1111.
  - `bus_wdata`: byte is replicated ×4; half is replicated ×2; word is passed through.
- Load extraction: byte lane addr[1:0] or half lane addr[1], extended per `uns`.
- Rules for signals outside their active states:
  - `rvalid` outside WAIT is ignored.
  - `gnt` outside REQ is ignored.
  - `mem_en` while busy is ignored; the control FSM must not issue it.

## Timing
- Reset values: state IDLE; `bus_req`, `bus_we`, `done`, `err`, `busy` = 0; `bus_addr`, `bus_be`, `bus_wdata`, `rdata` = 0.
- Best-case store: `mem_en` at cycle 0, `bus_req` at cycle 1 with `gnt`, `done` at cycle 2.
- Best-case load: `bus_req`/`gnt` at cycle 1, `rvalid` at cycle 2, `done` and valid `rdata` at cycle 3.
- `rvalid` may arrive at the earliest one cycle after `gnt`; it is never accepted in the `gnt` cycle.
- Reset asserted mid-operation: at the next edge, state returns to IDLE and `bus_req` goes low. An outstanding `rvalid` arriving later is ignored.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined: misaligned accesses (half with addr[0]=1; word with addr[1:0]≠0) go from IDLE straight to DONE with `err`; no bus request is issued.
- `LSU_MISALIGN_CHECK_EN` undefined: misaligned accesses are not checked. The low address bits are truncated: half uses addr[1], word uses lane 0. `err` comes only from the illegal-strobe and timeout cases.

## Structure
- Package `lsu_pkg` holds:
  - Size encodings: SZ_BYTE, SZ_HALF, SZ_WORD.
  - The 2-bit state encoding.
  - The default TIMEOUT_CYC.
- Sub-module `lsu_align` (combinational) holds byte-enable and store-replication generation plus load lane extraction and extension. It is shared by the top-level FSM.

## Test plan
- Store byte: addr 0x1003, wdata 0xA5, `gnt` immediate → `bus_addr` 0x1000, `be` 1000, `bus_wdata` 0xA5A5A5A5, `done` at cycle 2.
- Load half, signed: addr 0x2002, `bus_rdata` 0x80010000 → `rdata` 0xFFFF8001. Same access with `uns`=1 → `rdata` 0x00008001.
- `gnt` delayed 3 cycles and `rvalid` delayed 2 more → request held stable throughout, `done` exactly one cycle after `rvalid`.
- No `gnt` for 16 cycles → `done`+`err` pulse, `bus_req` low, `rdata` unchanged.
- Word load at 0x3002: with the macro → `err`, no `bus_req` ever asserted. Without the macro → `bus_addr` 0x3000, normal completion.
- Reset pulsed while in WAIT, then `rvalid` arrives → state IDLE, no `done`, `rdata` = 0.
